// File: rtl/div_seq.sv
//==============================================================================
// Module   : div_seq
// Purpose  : Sequential restoring divider, one quotient bit per cycle.
//            Define DIV_SEQ_SIGNED_EN for two's-complement (truncating) mode.
// Revision : 1.0
//==============================================================================
`default_nettype none

module div_seq #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  quo_q, quo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  quotient_q, quotient_d;
   logic [N-1:0]  remainder_q, remainder_d;
   logic          dbz_q, dbz_d;

   logic [N:0]    shift_val;
   logic [N:0]    diff;
   logic [N-1:0]  rem_next;
   logic [N-1:0]  quo_next;
   logic [N-1:0]  dividend_mag;
   logic [N-1:0]  divisor_mag;
   logic [N-1:0]  quo_fix;
   logic [N-1:0]  rem_fix;

   // The N+1-bit difference MSB is set exactly when the shifted remainder is
   // smaller than the divisor, because the partial remainder stays below it.
   assign shift_val = {rem_q, dvd_q[N-1]};
   assign diff      = shift_val - {1'b0, dvs_q};
   assign rem_next  = diff[N] ? shift_val[N-1:0] : diff[N-1:0];
   assign quo_next  = {quo_q[N-2:0], ~diff[N]};

`ifdef DIV_SEQ_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   // Magnitude of the most-negative value is itself read as unsigned.
   assign dividend_mag = dividend[N-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[N-1]  ? -divisor  : divisor;
   assign quo_fix      = neg_quo_q ? -quo_next : quo_next;
   assign rem_fix      = neg_rem_q ? -rem_next : rem_next;

   always_comb begin
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (state_q == S_IDLE && start) begin
         neg_quo_d = dividend[N-1] ^ divisor[N-1];
         neg_rem_d = dividend[N-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
   assign quo_fix      = quo_next;
   assign rem_fix      = rem_next;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  dvd_d   = dividend_mag;
                  dvs_d   = divisor_mag;
                  rem_d   = '0;
                  quo_d   = '0;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            dvd_d = {dvd_q[N-2:0], 1'b0};
            rem_d = rem_next;
            quo_d = quo_next;
            if (cnt_q == CW'(N - 1)) begin
               state_d     = S_DONE;
               quotient_d  = quo_fix;
               remainder_d = rem_fix;
               dbz_d       = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
//==============================================================================
// Module   : tb_div_seq
// Purpose  : Directed and random self-checking bench for div_seq (N=16).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_div_seq;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   div_seq #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Polls from the first sample after the accepting edge; lat=1 means done
   // is already up in that first cycle.
   task automatic wait_done(output int lat, output int busy_low);
      lat      = 1;
      busy_low = 0;
      while (!done && lat <= 40) begin
         if (!busy) busy_low++;
         @(posedge clk); #1;
         lat++;
      end
      if (!busy) busy_low++;
   endtask

   task automatic do_div(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ez, input int elat);
      int lat;
      int busy_low;
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = ~dd;
      divisor  = dv + 16'h0003;
      wait_done(lat, busy_low);
      check({tag, ".latency"}, lat, elat);
      check({tag, ".quotient"}, quotient, eq);
      check({tag, ".remainder"}, remainder, er);
      check({tag, ".div_by_zero"}, div_by_zero, ez);
      check({tag, ".busy_gap"}, busy_low, 0);
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, done, 1'b0);
      check({tag, ".idle_busy"}, busy, 1'b0);
      check({tag, ".hold_q"}, quotient, eq);
   endtask

   initial begin
      int lat;
      int busy_low;
      int done_seen;
      logic [N-1:0] a;
      logic [N-1:0] b;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", busy, 1'b0);
      check("reset.done", done, 1'b0);
      check("reset.quotient", quotient, 16'h0000);
      check("reset.remainder", remainder, 16'h0000);
      check("reset.dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst = 1'b0;

`ifndef DIV_SEQ_SIGNED_EN
      do_div("basic_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      do_div("div_zero", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
      do_div("ffff_by_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
      do_div("small_by_big", 16'd5, 16'd10, 16'd0, 16'd5, 1'b0, 17);
      do_div("abcd_by_ff", 16'hABCD, 16'h00FF, 16'h00AC, 16'h0079, 1'b0, 17);
      do_div("zero_num", 16'h0000, 16'd5, 16'h0000, 16'h0000, 1'b0, 17);
      do_div("equal", 16'd1000, 16'd1000, 16'd1, 16'd0, 1'b0, 17);

      // start held through RUN with other operands, then accepted after DONE
      @(negedge clk);
      dividend = 16'hFFFF;
      divisor  = 16'h0010;
      start    = 1'b1;
      @(posedge clk); #1;
      dividend = 16'd5;
      divisor  = 16'd1;
      wait_done(lat, busy_low);
      check("ignore.latency", lat, 17);
      check("ignore.quotient", quotient, 16'h0FFF);
      check("ignore.remainder", remainder, 16'h000F);
      @(posedge clk); #1;
      check("ignore.idle_after_done", busy, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b.accepted", busy, 1'b1);
      wait_done(lat, busy_low);
      check("b2b.latency", lat, 17);
      check("b2b.quotient", quotient, 16'd5);
      check("b2b.remainder", remainder, 16'd0);

      // reset during RUN cycle 5
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 16'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst.busy", busy, 1'b0);
      check("midrst.done", done, 1'b0);
      check("midrst.quotient", quotient, 16'h0000);
      check("midrst.remainder", remainder, 16'h0000);
      check("midrst.dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("midrst.no_done", done_seen, 0);
      do_div("after_rst_9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

      // reset and start in the same cycle: reset wins
      @(negedge clk);
      dividend = 16'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      rst      = 1'b1;
      @(posedge clk); #1;
      check("rst_prio.busy", busy, 1'b0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;

      for (int i = 0; i < 500; i++) begin
         a = N'($urandom);
         b = N'($urandom_range(1, 65535));
         do_div("random", a, b, a / b, a % b, 1'b0, 17);
      end
`else
      do_div("s_m7_2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17);
      do_div("s_7_m2", 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);
      do_div("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
      do_div("s_m100_m7", 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 17);
      do_div("s_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      do_div("s_div_zero", 16'hF000, 16'h0000, 16'hFFFF, 16'hF000, 1'b1, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
